sfifo_slave_emu: RTL and testbench
==================================

Name: sfifo_slave_emu

Overview:
Synthesizable cycle-level emulator of the USB controller's Slave FIFO (FX2 side), the responder to the FPGA's high-speed I/O master. It implements one OUT endpoint (host->FPGA, drained by master SLRD) and one IN endpoint (FPGA->host, filled by master SLWR and committed in packets). Host-side streams stand in for USB traffic. It is used in simulation benches and in loopback self-test builds.

Parameters:
USB_ENDPOINT_IN, 2, IN endpoint number; address = (EP-2)>>1.
USB_ENDPOINT_OUT, 6, OUT endpoint number; address = (EP-2)>>1.
PKT_WORDS, 256, IN auto-commit size in 16-bit words.
NBUF, 4, IN packet buffers, so IN depth = PKT_WORDS*NBUF.
OUT_DEPTH, 1024, OUT endpoint depth in words (power of 2).

Ports:
IFCLK  in  1  sole clock.
RESET  in  1  synchronous, active-high reset.
FIFOADR  in  2  endpoint select from master.
SLOE, SLRD, SLWR, PKTEND  in  1 each  active-low strobes from master.
FD_I  in  16  data driven by master.
FD_O  out  16  data toward master.
FD_OE  out  1  drive enable for FD_O (bench or top resolves the inout).
FLAGA  out  1  low = IN endpoint holds 0 words, committed or not.
FLAGB  out  1  low = IN endpoint full.
FLAGC  out  1  low = OUT endpoint empty.
h_out_data  in  16 / h_out_valid  in  1 / h_out_ready  out  1  host writes OUT endpoint.
h_in_data  out  16 / h_in_valid  out  1 / h_in_last  out  1 / h_in_ready  in  1  host reads committed IN data.
err_rd_empty, err_wr_full, err_addr  out  1 each  sticky errors.

Behaviour:
- Reset values: FD_OE=0, FD_O=0, FLAGA=0, FLAGB=1, FLAGC=0, h_out_ready=1, h_in_valid=0, h_in_last=0, all errors 0. All pointers and counters are zeroed; any in-flight packet is discarded. Reset wins over every simultaneous event.
- FLAGA, FLAGB and FLAGC are registered from pointer state, so they lag the causing event by exactly 1 cycle. They are independent of FIFOADR.
- FD_OE = ~SLOE & (FIFOADR == OUT_ADDR), combinational. FD_O = current OUT head word (first-word fall-through register); FD_O = 0 when OUT is empty.
- OUT pop:
  - Occurs at a posedge when SLRD=0, FIFOADR==OUT_ADDR and OUT is non-empty; the head advances and the next word appears after that edge.
  - SLRD=0 while OUT is empty: no pop, err_rd_empty set.
  - SLRD=0 with FIFOADR!=OUT_ADDR: err_addr set.
- OUT push: h_out_valid & h_out_ready. h_out_ready = OUT count < OUT_DEPTH. A push and a pop in the same cycle are both honoured and leave the count unchanged.
- IN write:
  - At a posedge with SLWR=0 and FIFOADR==IN_ADDR, FD_I is appended to the uncommitted packet.
  - If FLAGB is internally full, the word is dropped and err_wr_full is set.
  - SLWR=0 with the wrong address: err_addr set, word dropped.
- IN commit:
  - Triggered when the uncommitted length reaches PKT_WORDS (on the same edge as that last write), or by PKTEND=0 with FIFOADR==IN_ADDR.
  - PKTEND and SLWR in the same cycle: the word is included, then the packet is committed.
  - PKTEND with 0 uncommitted words (ZLP): ignored.
  - On commit, the end pointer is pushed to a boundary FIFO of depth NBUF.
- IN full: (wr - rd) == PKT_WORDS*NBUF, or NBUF packets are committed and none has been drained.
- Host IN read:
  - h_in_valid = committed data pending; h_in_last is high on the final word of each packet.
  - Pop on h_in_valid & h_in_ready; the boundary entry is released on pop of the last word.
- Pointers are 1 bit wider than their address for full/empty disambiguation and wrap modulo 2*depth.
- Internal states per IN packet: IDLE (no uncommitted words), FILL, COMMIT (single cycle, folded into the write edge). Host-drain state machine: WAIT_PKT -> STREAM -> WAIT_PKT after last.

Decomposition:
- Package sfifo_emu_pkg: endpoint-address function (EP-2)>>1, PKT_WORDS default, flag polarity constants.
- One sub-module, sfifo_emu_fifo: a generic FWFT synchronous FIFO with count. It is instantiated for the OUT data path and for the IN boundary FIFO. IN data storage and commit logic stay in the top module.

Test Plan:
- Host pushes 0x0001..0x0200 to OUT; master reads with SLOE=SLRD=0, FIFOADR=2'b10 -> FD_O sequence 0x0001..0x0200 in order; FLAGC falls 1 cycle after the 512th pop; no errors.
- Master writes 256 words 0xA000+i at FIFOADR=2'b00 -> auto-commit; FLAGA rises 1 cycle after the first write; host sees 256 words with h_in_last on 0xA0FF.
- Master writes 5 words, then PKTEND alone -> host packet of 5 words, last on the 5th. PKTEND with 0 pending -> no host output.
- Master writes 1024 words with h_in_ready=0 -> FLAGB low 1 cycle after word 1024. Word 1025 -> err_wr_full=1, word dropped.
- SLRD=0 on empty OUT -> err_rd_empty=1, FD_O=0. SLWR=0 with FIFOADR=2'b10 -> err_addr=1.
- RESET asserted mid-packet after 100 IN writes -> next cycle FLAGA=0, FLAGB=1, FLAGC=0, h_in_valid=0; subsequent traffic is correct.

Source files
------------

// File: rtl/sfifo_emu_pkg.sv
// sfifo_emu_pkg: shared constants and helpers for the slave FIFO emulator
package sfifo_emu_pkg;
  localparam int PKT_WORDS_DEF = 256;
  localparam logic FLAG_ON = 1'b0;
  function automatic logic [1:0] ep_addr(input int ep);
    return 2'((ep - 2) >> 1);
  endfunction
endpackage

// File: rtl/sfifo_emu_fifo.sv
// sfifo_emu_fifo: first-word fall-through synchronous FIFO with occupancy count
module sfifo_emu_fifo
  import sfifo_emu_pkg::*;
#(
  parameter int W = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             data,
  input  logic                     pop,
  output logic [W-1:0]             q,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign count = wp - rp;
  assign empty = wp == rp;
  assign do_push = push & (count != (AW+1)'(DEPTH));
  assign do_pop = pop & ~empty;
  assign q = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/sfifo_slave_emu.sv
// sfifo_slave_emu: cycle-level FX2 slave FIFO emulator with one OUT and one IN endpoint
module sfifo_slave_emu
  import sfifo_emu_pkg::*;
#(
  parameter int USB_ENDPOINT_IN = 2,
  parameter int USB_ENDPOINT_OUT = 6,
  parameter int PKT_WORDS = PKT_WORDS_DEF,
  parameter int NBUF = 4,
  parameter int OUT_DEPTH = 1024
) (
  input  logic        IFCLK,
  input  logic        RESET,
  input  logic [1:0]  FIFOADR,
  input  logic        SLOE,
  input  logic        SLRD,
  input  logic        SLWR,
  input  logic        PKTEND,
  input  logic [15:0] FD_I,
  output logic [15:0] FD_O,
  output logic        FD_OE,
  output logic        FLAGA,
  output logic        FLAGB,
  output logic        FLAGC,
  input  logic [15:0] h_out_data,
  input  logic        h_out_valid,
  output logic        h_out_ready,
  output logic [15:0] h_in_data,
  output logic        h_in_valid,
  output logic        h_in_last,
  input  logic        h_in_ready,
  output logic        err_rd_empty,
  output logic        err_wr_full,
  output logic        err_addr
);
  localparam logic [1:0] IN_ADDR = ep_addr(USB_ENDPOINT_IN);
  localparam logic [1:0] OUT_ADDR = ep_addr(USB_ENDPOINT_OUT);
  localparam int IN_DEPTH = PKT_WORDS * NBUF;
  localparam int AW = $clog2(IN_DEPTH);
  localparam int OCW = $clog2(OUT_DEPTH) + 1;
  localparam int BCW = $clog2(NBUF) + 1;
  logic [15:0] out_head;
  logic [15:0] in_mem [IN_DEPTH];
  logic [OCW-1:0] out_count;
  logic [BCW-1:0] bnd_count;
  logic [AW:0] wr, rd, cm, wr_n, pend_n, bnd_head;
  logic out_empty, bnd_empty, rd_req, wr_req, out_pop, in_full, wr_in, commit, in_pop;
  assign rd_req = ~SLRD & (FIFOADR == OUT_ADDR);
  assign wr_req = ~SLWR & (FIFOADR == IN_ADDR);
  assign out_pop = rd_req & ~out_empty;
  assign in_full = ((wr - rd) == (AW+1)'(IN_DEPTH)) | (bnd_count == BCW'(NBUF));
  assign wr_in = wr_req & ~in_full;
  assign wr_n = wr + (AW+1)'(wr_in);
  assign pend_n = wr_n - cm;
  // a word written alongside PKTEND joins the packet it closes
  assign commit = (wr_in & (pend_n == (AW+1)'(PKT_WORDS)))
                | (~PKTEND & (FIFOADR == IN_ADDR) & (pend_n != '0));
  assign in_pop = h_in_valid & h_in_ready;
  assign FD_OE = ~SLOE & (FIFOADR == OUT_ADDR);
  assign FD_O = out_empty ? '0 : out_head;
  assign h_out_ready = out_count < OCW'(OUT_DEPTH);
  assign h_in_valid = ~bnd_empty;
  assign h_in_last = h_in_valid & ((rd + 1'b1) == bnd_head);
  assign h_in_data = in_mem[rd[AW-1:0]];
  sfifo_emu_fifo #(.W(16), .DEPTH(OUT_DEPTH)) u_out (
    .clk(IFCLK), .rst(RESET), .push(h_out_valid & h_out_ready), .data(h_out_data),
    .pop(out_pop), .q(out_head), .count(out_count), .empty(out_empty)
  );
  // holds the end pointer of every committed, not yet fully drained packet
  sfifo_emu_fifo #(.W(AW+1), .DEPTH(NBUF)) u_bnd (
    .clk(IFCLK), .rst(RESET), .push(commit), .data(wr_n),
    .pop(in_pop & h_in_last), .q(bnd_head), .count(bnd_count), .empty(bnd_empty)
  );
  always_ff @(posedge IFCLK) begin
    if (wr_in && !RESET) in_mem[wr[AW-1:0]] <= FD_I;
  end
  always_ff @(posedge IFCLK) begin
    if (RESET) begin
      wr <= '0;
      rd <= '0;
      cm <= '0;
      FLAGA <= FLAG_ON;
      FLAGB <= ~FLAG_ON;
      FLAGC <= FLAG_ON;
      err_rd_empty <= 1'b0;
      err_wr_full <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      wr <= wr_n;
      rd <= rd + (AW+1)'(in_pop);
      if (commit) cm <= wr_n;
      FLAGA <= (wr == rd) ? FLAG_ON : ~FLAG_ON;
      FLAGB <= in_full ? FLAG_ON : ~FLAG_ON;
      FLAGC <= out_empty ? FLAG_ON : ~FLAG_ON;
      err_rd_empty <= err_rd_empty | (rd_req & out_empty);
      err_wr_full <= err_wr_full | (wr_req & in_full);
      err_addr <= err_addr | (~SLRD & (FIFOADR != OUT_ADDR)) | (~SLWR & (FIFOADR != IN_ADDR));
    end
  end
endmodule

// File: tb/tb_sfifo_slave_emu.sv
// tb_sfifo_slave_emu: directed stimulus against a queue-level model of the slave FIFO
module tb_sfifo_slave_emu;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, sloe, slrd, slwr, pktend, fd_oe, flaga, flagb, flagc;
  logic ho_valid, ho_ready, hi_valid, hi_last, hi_ready, e_rd, e_wr, e_ad;
  logic [1:0] adr;
  logic [15:0] fd_i, fd_o, ho_data, hi_data;
  int compared = 0, mismatched = 0;
  bit chk_en = 0;
  logic [15:0] out_q[$], pend[$], com[$];
  int plen[$];
  logic m_fa, m_fb, m_fc, m_erd, m_ewr, m_ead;

  sfifo_slave_emu dut (
    .IFCLK(clk), .RESET(rst), .FIFOADR(adr), .SLOE(sloe), .SLRD(slrd), .SLWR(slwr),
    .PKTEND(pktend), .FD_I(fd_i), .FD_O(fd_o), .FD_OE(fd_oe), .FLAGA(flaga), .FLAGB(flagb),
    .FLAGC(flagc), .h_out_data(ho_data), .h_out_valid(ho_valid), .h_out_ready(ho_ready),
    .h_in_data(hi_data), .h_in_valid(hi_valid), .h_in_last(hi_last), .h_in_ready(hi_ready),
    .err_rd_empty(e_rd), .err_wr_full(e_wr), .err_addr(e_ad)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model of the endpoints as word queues; flags capture the state before each edge
  task automatic model_edge();
    bit full, ho_push;
    if (rst) begin
      out_q.delete(); pend.delete(); com.delete(); plen.delete();
      m_fa = 0; m_fb = 1; m_fc = 0; m_erd = 0; m_ewr = 0; m_ead = 0;
      return;
    end
    full = (pend.size() + com.size()) == 1024 || plen.size() == 4;
    m_fa = (pend.size() + com.size()) != 0;
    m_fb = !full;
    m_fc = out_q.size() != 0;
    ho_push = ho_valid && out_q.size() < 1024;
    if (!slrd && adr == 2'b10) begin
      if (out_q.size() == 0) m_erd = 1;
      else void'(out_q.pop_front());
    end
    if ((!slrd && adr != 2'b10) || (!slwr && adr != 2'b00)) m_ead = 1;
    if (ho_push) out_q.push_back(ho_data);
    if (hi_ready && plen.size() > 0) begin
      void'(com.pop_front());
      plen[0]--;
      if (plen[0] == 0) void'(plen.pop_front());
    end
    if (!slwr && adr == 2'b00) begin
      if (full) m_ewr = 1;
      else pend.push_back(fd_i);
    end
    if (pend.size() == 256 || (!pktend && adr == 2'b00 && pend.size() > 0)) begin
      plen.push_back(pend.size());
      foreach (pend[i]) com.push_back(pend[i]);
      pend.delete();
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic compare();
    check("FD_OE", fd_oe, 16'(!sloe && adr == 2'b10));
    check("FD_O", fd_o, out_q.size() > 0 ? out_q[0] : 16'h0);
    check("FLAGA", flaga, 16'(m_fa));
    check("FLAGB", flagb, 16'(m_fb));
    check("FLAGC", flagc, 16'(m_fc));
    check("h_out_ready", ho_ready, 16'(out_q.size() < 1024));
    check("h_in_valid", hi_valid, 16'(plen.size() > 0));
    check("h_in_last", hi_last, 16'(plen.size() > 0 && plen[0] == 1));
    if (plen.size() > 0) check("h_in_data", hi_data, com[0]);
    check("err_rd_empty", e_rd, 16'(m_erd));
    check("err_wr_full", e_wr, 16'(m_ewr));
    check("err_addr", e_ad, 16'(m_ead));
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) compare();
  end

  task automatic write_in(input logic [15:0] base, input int n);
    adr = 2'b00;
    for (int i = 0; i < n; i++) begin
      slwr = 0;
      fd_i = base + 16'(i);
      step();
    end
    slwr = 1;
  endtask

  task automatic drain(input string tag, input int exp_n, input logic [15:0] exp_first, input logic [15:0] exp_last);
    int n, lastidx, budget;
    logic [15:0] first, lastw;
    n = 0; lastidx = -1; budget = 0; first = 0; lastw = 0;
    hi_ready = 1;
    while ((n == 0 || hi_valid) && budget < 1200) begin
      if (hi_valid) begin
        if (n == 0) first = hi_data;
        if (hi_last) begin
          lastw = hi_data;
          lastidx = n;
        end
        n++;
      end
      step();
      budget++;
    end
    hi_ready = 0;
    check($sformatf("%s count", tag), 16'(n), 16'(exp_n));
    check($sformatf("%s first", tag), first, exp_first);
    check($sformatf("%s last word", tag), lastw, exp_last);
    check($sformatf("%s last index", tag), 16'(lastidx), 16'(exp_n - 1));
  endtask

  initial begin
    rst = 1; adr = 2'b00; sloe = 1; slrd = 1; slwr = 1; pktend = 1;
    fd_i = 0; ho_data = 0; ho_valid = 0; hi_ready = 0;
    step();
    chk_en = 1;
    step();
    rst = 0;
    check("reset FLAGA", flaga, 16'h0);
    check("reset FLAGB", flagb, 16'h1);
    check("reset FLAGC", flagc, 16'h0);
    check("reset h_out_ready", ho_ready, 16'h1);
    check("reset h_in_valid", hi_valid, 16'h0);

    ho_valid = 1;
    for (int i = 0; i < 512; i++) begin
      ho_data = 16'(i + 1);
      step();
    end
    ho_valid = 0;
    check("out head", fd_o, 16'h0001);
    check("FLAGC filled", flagc, 16'h1);
    adr = 2'b10; sloe = 0; slrd = 0;
    repeat (255) step();
    check("out mid", fd_o, 16'h0100);
    repeat (257) step();
    slrd = 1;
    check("FLAGC lags last pop", flagc, 16'h1);
    check("out empty FD_O", fd_o, 16'h0);
    step();
    check("FLAGC fell", flagc, 16'h0);
    check("no rd error", e_rd, 16'h0);
    sloe = 1;

    adr = 2'b00;
    for (int i = 0; i < 256; i++) begin
      slwr = 0;
      fd_i = 16'hA000 + 16'(i);
      step();
      if (i == 0) check("FLAGA lag", flaga, 16'h0);
      if (i == 1) check("FLAGA rose", flaga, 16'h1);
    end
    slwr = 1;
    drain("auto", 256, 16'hA000, 16'hA0FF);

    write_in(16'hB000, 5);
    check("no commit yet", hi_valid, 16'h0);
    pktend = 0;
    step();
    pktend = 1;
    check("pktend commit", hi_valid, 16'h1);
    drain("pktend", 5, 16'hB000, 16'hB004);
    pktend = 0;
    step();
    pktend = 1;
    step();
    check("zlp ignored", hi_valid, 16'h0);

    write_in(16'hC000, 1024);
    check("FLAGB lags full", flagb, 16'h1);
    slwr = 0; fd_i = 16'hDEAD;
    step();
    slwr = 1;
    check("FLAGB full", flagb, 16'h0);
    check("err_wr_full", e_wr, 16'h1);
    drain("full", 1024, 16'hC000, 16'hC3FF);

    adr = 2'b10; slrd = 0;
    step();
    slrd = 1;
    check("err_rd_empty", e_rd, 16'h1);
    check("empty read FD_O", fd_o, 16'h0);
    slwr = 0;
    step();
    slwr = 1;
    check("err_addr", e_ad, 16'h1);

    ho_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ho_data = 16'h5000 + 16'(i);
      step();
    end
    ho_valid = 0;
    write_in(16'hD000, 100);
    slwr = 0; fd_i = 16'hD064; rst = 1;
    step();
    rst = 0; slwr = 1;
    check("rst FLAGA", flaga, 16'h0);
    check("rst FLAGB", flagb, 16'h1);
    check("rst FLAGC", flagc, 16'h0);
    check("rst h_in_valid", hi_valid, 16'h0);
    check("rst errors", {13'b0, e_rd, e_wr, e_ad}, 16'h0);

    write_in(16'hE000, 2);
    slwr = 0; pktend = 0; fd_i = 16'hE002;
    step();
    slwr = 1; pktend = 1;
    drain("post-reset", 3, 16'hE000, 16'hE002);

    ho_valid = 1; ho_data = 16'hF000;
    step();
    adr = 2'b10; slrd = 0;
    for (int i = 1; i < 5; i++) begin
      ho_data = 16'hF000 + 16'(i);
      step();
    end
    ho_valid = 0;
    check("push+pop head", fd_o, 16'hF004);
    step();
    slrd = 1; adr = 2'b00;
    check("push+pop drained", fd_o, 16'h0);
    check("push+pop no error", e_rd, 16'h0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
